// File: rtl/caches_pkg.sv
// Shared types and defaults for the cache-to-memory arbiter.
package caches_pkg;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned BEATS_DEF       = 2;
  localparam int unsigned DSTREAK_MAX_DEF = 2;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DREAD  = 2'd2,
    DWRITE = 2'd3
  } arb_state_t;

  // Bits needed to hold the values 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/arb_fair_counter.sv
// Saturating count of dcache blocks granted back-to-back while icache waits.
module arb_fair_counter
  import caches_pkg::*;
#(
  parameter int unsigned MAX = DSTREAK_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max_c
);

  localparam int unsigned W = cnt_width(MAX);

  logic [W-1:0] count;

  assign at_max_c = (count == W'(MAX));

  // Clear wins over increment; increment stops at MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max_c) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache reads and dcache reads/writes onto a single memory port,
// one multi-beat block at a time, with a fairness limit on dcache streaks.
module mem_arbiter
  import caches_pkg::*;
#(
  parameter int unsigned BEATS       = BEATS_DEF,
  parameter int unsigned DSTREAK_MAX = DSTREAK_MAX_DEF
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  iREN,
  input  word_t iaddr,
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t dstore,
  output logic  iwait,
  output logic  dwait,
  output word_t iload,
  output word_t dload,
  output logic  load_done,
  output logic  store_done,
  output logic  mem_ren,
  output logic  mem_wen,
  output word_t mem_addr,
  output word_t mem_store,
  input  word_t mem_load,
  input  logic  mem_ack
);

  localparam int unsigned      BEAT_W    = cnt_width(BEATS - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [BEAT_W-1:0] beat;
  logic [BEAT_W-1:0] beat_nxt;
  logic              streak_max;
  logic              streak_inc;
  logic              streak_clr;
  logic              d_own_req;
  word_t             beat_off;

  // Owner supplies the block base; each beat advances by one 4-byte word.
  assign beat_off  = word_t'(beat) << 2;
  assign d_own_req = (state == DWRITE) ? dWEN : dREN;

  arb_fair_counter #(
    .MAX (DSTREAK_MAX)
  ) u_fair (
    .clk      (CLK),
    .rst      (RST),
    .inc      (streak_inc),
    .clr      (streak_clr),
    .at_max_c (streak_max)
  );

  // State and beat registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
    end
  end

  // Next-state, beat accounting and the combinational memory/cache outputs.
  always_comb begin
    state_nxt  = state;
    beat_nxt   = beat;
    iwait      = 1'b1;
    dwait      = 1'b1;
    iload      = '0;
    dload      = '0;
    load_done  = 1'b0;
    store_done = 1'b0;
    mem_ren    = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = '0;
    mem_store  = '0;
    streak_inc = 1'b0;
    streak_clr = 1'b0;

    unique case (state)
      IDLE: begin
        beat_nxt = '0;
        if (iREN && streak_max) begin
          state_nxt = IGRANT;
        end else if (dWEN) begin
          state_nxt = DWRITE;
        end else if (dREN) begin
          state_nxt = DREAD;
        end else if (iREN) begin
          state_nxt = IGRANT;
        end
      end

      IGRANT: begin
        mem_ren  = 1'b1;
        mem_addr = iaddr + beat_off;
        if (mem_ack) begin
          iwait = 1'b0;
          iload = mem_load;
          if (beat == LAST_BEAT) begin
            state_nxt  = IDLE;
            beat_nxt   = '0;
            streak_clr = 1'b1;
          end else begin
            beat_nxt = beat + BEAT_W'(1);
          end
        end else if (!iREN) begin
          state_nxt = IDLE;
          beat_nxt  = '0;
        end
      end

      DREAD, DWRITE: begin
        mem_ren  = (state == DREAD);
        mem_wen  = (state == DWRITE);
        mem_addr = daddr + beat_off;
        if (state == DWRITE) begin
          mem_store = dstore;
        end
        if (mem_ack) begin
          dwait      = 1'b0;
          dload      = mem_load;
          load_done  = (state == DREAD);
          store_done = (state == DWRITE);
          if (beat == LAST_BEAT) begin
            state_nxt  = IDLE;
            beat_nxt   = '0;
            streak_inc = iREN;
          end else begin
            beat_nxt = beat + BEAT_W'(1);
          end
        end else if (!d_own_req) begin
          state_nxt = IDLE;
          beat_nxt  = '0;
        end
      end
    endcase
  end

endmodule
